// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM state encodings,
// program store geometry and load stream framing constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LEN  = 2'd1,
        LDR_DATA = 2'd2,
        LDR_CHK  = 2'd3
    } ldr_state_t;

    localparam int PROG_DATAWIDTH = 8;
    localparam int PROG_ADDWIDTH  = 7;
    localparam int PROG_DEPTH     = 2 ** PROG_ADDWIDTH;

    // Stream framing: one length byte, payload, one XOR checksum byte.
    localparam int LDR_HDR_LEN = 1;
    localparam int LDR_TRL_LEN = 1;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in (in_valid/in_data/in_ready) and program memory
// write port out (mem_wr_en/mem_wr_addr/mem_wr_data).
// master: the loader side. slave: stream source plus memory side.
interface program_loader_if
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = PROG_DATAWIDTH,
    parameter int ADDWIDTH  = PROG_ADDWIDTH
);
    logic                 in_valid;
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_ready;
    logic                 mem_wr_en;
    logic [ADDWIDTH-1:0]  mem_wr_addr;
    logic [DATAWIDTH-1:0] mem_wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Byte-serial loader filling program memory; holds the core in reset
// until a checksum-verified image is loaded.
// Ports: clk, rst_n (sync, active-low), start, bus (stream + mem write),
// cpu_rst_n, busy, done (sticky), chk_err (sticky).
module program_loader
    import cpu_pkg::*;
#(
    parameter int DATAWIDTH = PROG_DATAWIDTH,
    parameter int ADDWIDTH  = PROG_ADDWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    program_loader_if.master        bus,
    output logic                    cpu_rst_n,
    output logic                    busy,
    output logic                    done,
    output logic                    chk_err
);

    ldr_state_t state_q;
    ldr_state_t state_d;

    logic [ADDWIDTH-1:0]  addr_q;
    logic [7:0]           remain_q;
    logic [DATAWIDTH-1:0] acc_q;

    logic                 wr_en_q;
    logic [ADDWIDTH-1:0]  wr_addr_q;
    logic [DATAWIDTH-1:0] wr_data_q;

    logic ready;
    logic xfer;

    // Ready depends on registered state only, never on in_valid.
    assign ready = (state_q != LDR_IDLE);
    assign xfer  = bus.in_valid & ready;

    assign bus.in_ready    = ready;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LDR_IDLE: begin
                if (start) state_d = LDR_LEN;
            end
            LDR_LEN: begin
                if (xfer) begin
                    state_d = (bus.in_data == '0) ? LDR_CHK : LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (xfer && remain_q == 8'd1) state_d = LDR_CHK;
            end
            LDR_CHK: begin
                if (xfer) state_d = LDR_IDLE;
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            remain_q  <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                LDR_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        chk_err   <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        addr_q    <= '0;
                        remain_q  <= '0;
                        acc_q     <= '0;
                    end
                end
                LDR_LEN: begin
                    if (xfer) remain_q <= bus.in_data;
                end
                LDR_DATA: begin
                    if (xfer) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= bus.in_data;
                        // Wraps naturally at the memory depth.
                        addr_q    <= addr_q + 1'b1;
                        acc_q     <= acc_q ^ bus.in_data;
                        remain_q  <= remain_q - 8'd1;
                    end
                end
                LDR_CHK: begin
                    if (xfer) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        chk_err   <= (bus.in_data != acc_q);
                        cpu_rst_n <= (bus.in_data == acc_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
